// File: rtl/axil_master_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axil_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;
    localparam logic [2:0] PROT_DEFAULT = 3'b000;
endpackage

// File: rtl/axil_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, with wrap.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    int            jj;
    logic [IW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        jj    = 0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            jj = (int'(ptr_i) + k) % N;
            j  = IW'(jj);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end
endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin share of one AXI4-Lite master port among NUM_REQ requesters,
// one full read or write transaction per grant.
module axil_master_arbiter
    import axil_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                             ACLK,
    input  logic                             ARESETN,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0] req_wstrb,
    output logic [NUM_REQ-1:0]               req_done,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_resp,
    output logic [NUM_REQ-1:0]               grant,
    output logic                             busy,
    output logic                             TXN_DONE,
    output logic                             ERROR,
    output logic                             timeout,
    output logic [ADDR_WIDTH-1:0]            M_AXI_AWADDR,
    output logic [2:0]                       M_AXI_AWPROT,
    output logic                             M_AXI_AWVALID,
    input  logic                             M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]            M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
    output logic                             M_AXI_WVALID,
    input  logic                             M_AXI_WREADY,
    input  logic [1:0]                       M_AXI_BRESP,
    input  logic                             M_AXI_BVALID,
    output logic                             M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]            M_AXI_ARADDR,
    output logic [2:0]                       M_AXI_ARPROT,
    output logic                             M_AXI_ARVALID,
    input  logic                             M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]            M_AXI_RDATA,
    input  logic [1:0]                       M_AXI_RRESP,
    input  logic                             M_AXI_RVALID,
    output logic                             M_AXI_RREADY
);
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q;
    logic [IW-1:0]          idx_q, ptr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic                   write_q;
    logic                   awvalid_q, wvalid_q, arvalid_q, bready_q, rready_q;
    logic                   aw_done_q, w_done_q, ar_done_q;
    logic [1:0]             resp_q;
    logic                   txn_done_q, error_q, timeout_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    logic                   addr_done, rsp_hs, waiting;

    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
    logic [STRB_W-1:0]      wstrb_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_arr[g] = req_wstrb[g*STRB_W +: STRB_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // RESP is entered only once the registered done flags show both channels finished.
    assign addr_done = write_q ? (aw_done_q & w_done_q) : ar_done_q;
    assign rsp_hs    = (bready_q & M_AXI_BVALID) | (rready_q & M_AXI_RVALID);
    assign waiting   = (state_q == ADDR || state_q == RESP) && (state_q == state_d);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any)   state_d = ADDR;
            ADDR:    if (addr_done) state_d = RESP;
            RESP:    if (rsp_hs)    state_d = DONE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            grant_q    <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            write_q    <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            bready_q   <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ar_done_q  <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= '0;
            txn_done_q <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (arb_any) begin
                    grant_q   <= arb_gnt;
                    idx_q     <= arb_idx;
                    addr_q    <= addr_arr[arb_idx];
                    wdata_q   <= wdata_arr[arb_idx];
                    wstrb_q   <= wstrb_arr[arb_idx];
                    write_q   <= req_write[arb_idx];
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    ar_done_q <= 1'b0;
                end
                ADDR: begin
                    if (write_q) begin
                        if (!aw_done_q) begin
                            if (awvalid_q && M_AXI_AWREADY) begin
                                awvalid_q <= 1'b0;
                                aw_done_q <= 1'b1;
                            end else awvalid_q <= 1'b1;
                        end
                        if (!w_done_q) begin
                            if (wvalid_q && M_AXI_WREADY) begin
                                wvalid_q <= 1'b0;
                                w_done_q <= 1'b1;
                            end else wvalid_q <= 1'b1;
                        end
                    end else if (!ar_done_q) begin
                        if (arvalid_q && M_AXI_ARREADY) begin
                            arvalid_q <= 1'b0;
                            ar_done_q <= 1'b1;
                        end else arvalid_q <= 1'b1;
                    end
                    if (addr_done) begin
                        bready_q <= write_q;
                        rready_q <= ~write_q;
                    end
                end
                RESP: if (rsp_hs) begin
                    resp_q   <= write_q ? M_AXI_BRESP : M_AXI_RRESP;
                    rdata_q  <= write_q ? '0 : M_AXI_RDATA;
                    bready_q <= 1'b0;
                    rready_q <= 1'b0;
                end
                default: begin
                    grant_q    <= '0;
                    ptr_q      <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                    txn_done_q <= 1'b1;
                    if (resp_q != RESP_OKAY) error_q <= 1'b1;
                end
            endcase

            // Stall watchdog: flags only, the transaction keeps waiting.
            if (state_q != state_d) cnt_q <= '0;
            else if (waiting && cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_q <= cnt_q + 1'b1;
            if (waiting && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_q <= 1'b1;
                error_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        req_done      = (state_q == DONE) ? grant_q : '0;
        grant         = grant_q;
        busy          = (state_q != IDLE);
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
        TXN_DONE      = txn_done_q;
        ERROR         = error_q;
        timeout       = timeout_q;
        M_AXI_AWADDR  = addr_q;
        M_AXI_AWPROT  = PROT_DEFAULT;
        M_AXI_AWVALID = awvalid_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = wstrb_q;
        M_AXI_WVALID  = wvalid_q;
        M_AXI_BREADY  = bready_q;
        M_AXI_ARADDR  = addr_q;
        M_AXI_ARPROT  = PROT_DEFAULT;
        M_AXI_ARVALID = arvalid_q;
        M_AXI_RREADY  = rready_q;
    end
endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench: behavioural AXI4-Lite slave with programmable ready delays.
module tb_axil_master_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESETN;
    always #5 ACLK = ~ACLK;

    logic [N-1:0]    req_valid, req_write, req_done, grant;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*4-1:0]  req_wstrb;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;
    logic            busy, TXN_DONE, ERROR, timeout;
    logic [AW-1:0]   AWADDR, ARADDR;
    logic [2:0]      AWPROT, ARPROT;
    logic            AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic            ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]   WDATA, RDATA;
    logic [3:0]      WSTRB;
    logic [1:0]      BRESP, RRESP;

    axil_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_done(req_done),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .grant(grant), .busy(busy),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR), .timeout(timeout),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    // ---------------- slave model ----------------
    int          aw_dly, w_dly, ar_dly;
    logic [1:0]  bresp_cfg, rresp_cfg;
    int          aw_wait, w_wait, ar_wait, b_hs_cnt;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_s, wdata_s;
    logic [3:0]  wstrb_s;
    logic [31:0] mem [8];

    assign AWREADY = AWVALID && (aw_wait >= aw_dly);
    assign WREADY  = WVALID && (w_wait >= w_dly);
    assign ARREADY = ARVALID && (ar_wait >= ar_dly);
    wire        aw_hs = AWVALID && AWREADY;
    wire        w_hs  = WVALID && WREADY;
    wire [31:0] b_addr = aw_hs ? AWADDR : aw_addr_s;
    wire [31:0] b_data = w_hs ? WDATA : wdata_s;
    wire [3:0]  b_strb = w_hs ? WSTRB : wstrb_s;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_s <= '0; wdata_s <= '0; wstrb_s <= '0;
            BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            if (aw_hs) begin aw_wait <= 0; aw_got <= 1'b1; aw_addr_s <= AWADDR; end
            else if (AWVALID) aw_wait <= aw_wait + 1;
            if (w_hs) begin w_wait <= 0; w_got <= 1'b1; wdata_s <= WDATA; wstrb_s <= WSTRB; end
            else if (WVALID) w_wait <= w_wait + 1;
            if (BVALID && BREADY) begin BVALID <= 1'b0; b_hs_cnt <= b_hs_cnt + 1; end
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                BVALID <= 1'b1; BRESP <= bresp_cfg;
                aw_got <= 1'b0; w_got <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (b_strb[b]) mem[b_addr[4:2]][8*b +: 8] <= b_data[8*b +: 8];
            end
            if (RVALID && RREADY) RVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                ar_wait <= 0; RVALID <= 1'b1; RDATA <= mem[ARADDR[4:2]]; RRESP <= rresp_cfg;
            end else if (ARVALID) ar_wait <= ar_wait + 1;
        end
    end

    // ---------------- checking ----------------
    int n_chk = 0, n_pass = 0;
    int ptr_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        bit          wr;
        int          rq;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        bit          exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int k);
        int lat;
        logic [31:0] rd;
        logic [1:0]  rs;
        lat = 0;
        bresp_cfg = v.sresp; rresp_cfg = v.sresp;
        req_write[v.rq] = v.wr;
        req_addr[v.rq*AW +: AW]  = v.addr;
        req_wdata[v.rq*DW +: DW] = v.wdata;
        req_wstrb[v.rq*4 +: 4]   = v.strb;
        req_valid[v.rq] = 1'b1;
        while (lat < 40) begin
            @(posedge ACLK); lat++;
            @(negedge ACLK);
            if (req_done[v.rq]) break;
        end
        rd = rsp_rdata; rs = rsp_resp;
        req_valid[v.rq] = 1'b0;
        ptr_m = (v.rq + 1) % N;
        @(negedge ACLK);
        chk($sformatf("v%0d latency", k), lat, 5);
        chk($sformatf("v%0d rdata", k), rd, v.exp_rdata);
        chk($sformatf("v%0d resp", k), 32'(rs), 32'(v.exp_resp));
        chk($sformatf("v%0d TXN_DONE", k), 32'(TXN_DONE), 1);
        chk($sformatf("v%0d ERROR", k), 32'(ERROR), 32'(v.exp_err));
    endtask

    initial begin
        int order[4];
        int got, cyc, b0;

        vecs[0] = '{1'b1, 0, 32'h4000_0000, 32'h0101_FFFF, 4'hF, 2'b00, 32'h0,         2'b00, 1'b0};
        vecs[1] = '{1'b1, 1, 32'h4000_0004, 32'hABCD_0001, 4'hF, 2'b00, 32'h0,         2'b00, 1'b0};
        vecs[2] = '{1'b0, 1, 32'h4000_0004, 32'h0,         4'h0, 2'b00, 32'hABCD_0001, 2'b00, 1'b0};
        vecs[3] = '{1'b0, 0, 32'h4000_0000, 32'h0,         4'h0, 2'b00, 32'h0101_FFFF, 2'b00, 1'b0};
        vecs[4] = '{1'b0, 0, 32'h4000_0004, 32'h0,         4'h0, 2'b10, 32'hABCD_0001, 2'b10, 1'b1};
        vecs[5] = '{1'b1, 1, 32'h4000_0008, 32'h1234_5678, 4'hF, 2'b00, 32'h0,         2'b00, 1'b1};
        vecs[6] = '{1'b1, 0, 32'h4000_0008, 32'hFFFF_FFFF, 4'h3, 2'b00, 32'h0,         2'b00, 1'b1};
        vecs[7] = '{1'b0, 1, 32'h4000_0008, 32'h0,         4'h0, 2'b00, 32'h1234_FFFF, 2'b00, 1'b1};

        ARESETN = 1'b0; b_hs_cnt = 0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        aw_dly = 0; w_dly = 0; ar_dly = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        repeat (2) @(negedge ACLK);
        chk("reset grant", 32'(grant), 0);
        chk("reset busy/flags", {28'd0, busy, TXN_DONE, ERROR, timeout}, 0);
        chk("reset valids", {28'd0, AWVALID, WVALID, ARVALID, BREADY | RREADY}, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Same-cycle AW/W launch on the first write
        req_write[0] = 1'b1; req_addr[0 +: AW] = 32'h4000_0000; req_valid[0] = 1'b1;
        cyc = 0;
        while (!AWVALID && !WVALID && cyc < 10) begin @(negedge ACLK); cyc++; end
        chk("aw/w together", {30'd0, AWVALID, WVALID}, 32'h3);
        req_valid[0] = 1'b0;
        cyc = 0;
        while (!req_done[0] && cyc < 20) begin @(negedge ACLK); cyc++; end
        repeat (2) @(negedge ACLK);

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Both requesters held: strict alternation from the current pointer
        req_write = '0; req_addr = {32'h4000_0004, 32'h4000_0000}; req_valid = 2'b11;
        got = 0; cyc = 0;
        while (got < 4 && cyc < 100) begin
            @(negedge ACLK); cyc++;
            if (req_done == 2'b01) begin order[got] = 0; got++; end
            else if (req_done == 2'b10) begin order[got] = 1; got++; end
        end
        req_valid = '0;
        chk("alternation count", got, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("alternation %0d", k), order[k], (ptr_m + k) % N);
        repeat (3) @(negedge ACLK);

        // W accepted well before AW, then the reverse
        for (int pass = 0; pass < 2; pass++) begin
            aw_dly = (pass == 0) ? 3 : 0;
            w_dly  = (pass == 0) ? 0 : 3;
            b0 = b_hs_cnt;
            req_write[0] = 1'b1; req_addr[0 +: AW] = 32'h4000_0010;
            req_wdata[0 +: DW] = 32'h55AA_55AA; req_wstrb[0 +: 4] = 4'hF; req_valid[0] = 1'b1;
            cyc = 0;
            while (cyc < 20 && !((pass == 0) ? (WVALID && WREADY) : (AWVALID && AWREADY))) begin
                @(negedge ACLK); cyc++;
            end
            @(negedge ACLK);
            chk($sformatf("split%0d early drop", pass), {30'd0, AWVALID, WVALID}, (pass == 0) ? 32'h2 : 32'h1);
            cyc = 0;
            while (!req_done[0] && cyc < 30) begin @(negedge ACLK); cyc++; end
            req_valid[0] = 1'b0;
            chk($sformatf("split%0d done", pass), 32'(req_done[0]), 1);
            repeat (2) @(negedge ACLK);
            chk($sformatf("split%0d B count", pass), b_hs_cnt - b0, 1);
        end
        aw_dly = 0; w_dly = 0;

        // Reset clears sticky flags, then ARREADY never comes
        ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("re-reset flags", {30'd0, TXN_DONE, ERROR}, 0);
        ar_dly = 1000; rresp_cfg = 2'b00;
        req_write[0] = 1'b0; req_addr[0 +: AW] = 32'h4000_0000; req_valid[0] = 1'b1;
        cyc = 0;
        while (grant == '0 && cyc < 10) begin @(negedge ACLK); cyc++; end
        chk("timeout grant", 32'(grant), 1);
        repeat (15) @(negedge ACLK);
        chk("timeout before limit", 32'(timeout), 0);
        @(negedge ACLK);
        chk("timeout at limit", 32'(timeout), 1);
        chk("timeout ERROR", 32'(ERROR), 1);
        chk("ARVALID held", 32'(ARVALID), 1);
        #2 ARESETN = 1'b0;
        #1;
        chk("async grant/done", {28'd0, grant, req_done}, 0);
        chk("async flags", {28'd0, busy, TXN_DONE, ERROR, timeout}, 0);
        chk("async valids", {28'd0, AWVALID, WVALID, ARVALID, BREADY | RREADY}, 0);
        chk("async rsp", rsp_rdata | 32'(rsp_resp), 0);
        req_valid = '0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/axil_master_arbiter.md
Name: axil_master_arbiter

Overview:
- Shares the single M00_AXI AXI4-Lite master port of the Hast_IP shell among NUM_REQ internal requesters (hardware-side register/memory accessors).
- Grants one requester at a time in round-robin order, then runs one complete AXI4-Lite read or write transaction (AW/W/B or AR/R).
- Returns read data and response to the granted requester.
- Exposes the INIT_AXI_TXN / TXN_DONE / ERROR style status used by the framework benches.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 only)
- TIMEOUT_CYCLES, 1023, cycles without slave response before the sticky timeout flag sets

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request, level held until req_done
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- req_wstrb  in  NUM_REQ*4  flattened byte strobes
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_WIDTH  read data, valid with req_done
- rsp_resp  out  2  BRESP/RRESP, valid with req_done
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- busy  out  1  transaction in flight
- TXN_DONE  out  1  sticky; set at first completion, cleared by reset only
- ERROR  out  1  sticky; set on any non-OKAY response or timeout
- timeout  out  1  sticky timeout flag
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channel signals. AWPROT and ARPROT are tied to 3'b000.

Behaviour:
- Reset (async, ARESETN low): state=IDLE. Outputs grant, req_done, busy, TXN_DONE, ERROR, timeout, all VALID/READY, rsp_rdata, rsp_resp = 0. RR pointer = 0.
- States: IDLE -> ADDR -> RESP -> DONE -> IDLE.
- IDLE: if any req_valid is set, pick the first set bit searching from the RR pointer upward with wrap. Register addr/wdata/wstrb/write from that requester and set grant. Next state ADDR. Grant is registered: the AXI VALID asserts 1 cycle after the grant decision.
- ADDR, write: AWVALID and WVALID assert together. Each drops independently in the cycle after its READY is sampled high. When both have completed, go to RESP with BREADY=1. Same-cycle AWREADY and WREADY is legal and must be handled. W may not be delayed until AW completes.
- ADDR, read: ARVALID until ARREADY, then RESP with RREADY=1.
- RESP: on BVALID&BREADY (or RVALID&RREADY), capture resp and rdata (rdata=0 for writes), drop READY, go to DONE.
- DONE: pulse req_done[granted] for exactly 1 cycle. Set TXN_DONE. Set ERROR if resp != 2'b00. Set RR pointer = granted+1 mod NUM_REQ. Clear grant. Return to IDLE. A new grant is possible no earlier than the cycle after DONE, giving a minimum of 1 idle cycle between transactions.
- Addresses and data stay stable while VALID is high (AXI rule). The requester's inputs are ignored after capture, so a requester changing its inputs mid-transaction has no effect.
- Timeout: counter runs in ADDR/RESP and resets on each state entry. When it reaches TIMEOUT_CYCLES, set timeout and ERROR. The transaction is not aborted (AXI forbids dropping VALID) and keeps waiting.
- A requester dropping req_valid after grant does not cancel the transaction; it still receives req_done.
- A requester holding req_valid through DONE is re-eligible only after all other pending requesters have been served (fairness).
- Minimum write latency, req_valid to req_done, with zero-wait slave: 5 cycles.

Decomposition:
- Package axil_arb_pkg holds: state enum (IDLE, ADDR, RESP, DONE); RESP_OKAY=2'b00, RESP_SLVERR=2'b10; PROT_DEFAULT=3'b000.
- Sub-module rr_arbiter: combinational round-robin priority pick from req vector and pointer. Outputs one-hot grant and index. Reusable elsewhere.

Test Plan:
- Single write, req 0, addr 0x4000_0000, data 0x0101FFFF, zero-wait slave -> AWVALID and WVALID same cycle; req_done[0] 5 cycles after req_valid; rsp_resp=0; TXN_DONE=1; ERROR=0.
- Write then read of 0x4000_0004, data 0xabcd0001, from req 1 -> rsp_rdata=0xabcd0001 with req_done[1].
- Both requesters held continuously -> grants alternate 0,1,0,1 over 4 transactions; no requester is served twice in a row.
- Slave returns WREADY 3 cycles before AWREADY, then the reverse -> each VALID drops independently; exactly one B handshake.
- Read returning RRESP=2'b10 -> rsp_resp=2'b10, ERROR sticky 1; the following OKAY transaction leaves ERROR at 1.
- Slave never asserts ARREADY, TIMEOUT_CYCLES=16 -> timeout and ERROR set at cycle 16 while ARVALID stays high. Asserting ARESETN low mid-wait returns all outputs to 0 asynchronously.
